// File: rtl/txt_wr_arbiter.sv
// txt_wr_arbiter: shares the text-screen RAM write port between two
// requesters (A: Life engine, B: status/text writer) and a full-screen fill
// engine. All outputs are registered; at most one RAM write per clock.
//
// Handshake: a requester raises req with row/col/data stable (req is its
// valid). The write is accepted on the edge where its ack rises; ack is a
// one-cycle accept pulse. A requester whose ack is currently high is not
// eligible, so a req still held in the ack cycle cannot be written twice.
// Dropping req before ack is allowed and leaves no write behind.
module txt_wr_arbiter #(
    parameter int COLS = 40,
    parameter int ROWS = 30
) (
    input  logic        pixel_clock,
    input  logic        reset,

    input  logic        a_req,
    input  logic [4:0]  a_row,
    input  logic [5:0]  a_col,
    input  logic [15:0] a_data,
    output logic        a_ack,

    input  logic        b_req,
    input  logic [4:0]  b_row,
    input  logic [5:0]  b_col,
    input  logic [15:0] b_data,
    output logic        b_ack,

    input  logic        fill_start,
    input  logic [15:0] fill_data,
    output logic        fill_busy,
    output logic        fill_done,

    output logic [12:0] wradr,
    output logic [15:0] wrdata,
    output logic        wren,

    output logic [1:0]  fsm_state
);

    localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);
    localparam logic [5:0] COL_LAST = 6'(COLS - 1);
    localparam logic [4:0] ROW_LIM  = 5'(ROWS);
    localparam logic [5:0] COL_LIM  = 6'(COLS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [4:0]  row, row_nx;
    logic [5:0]  col, col_nx;
    logic [15:0] fill_word, fill_word_nx;
    logic        last_b, last_b_nx;

    logic        wren_nx;
    logic [12:0] wradr_nx;
    logic [15:0] wrdata_nx;
    logic        a_ack_nx, b_ack_nx;
    logic        busy_nx, done_nx;

    logic        a_elig, b_elig;
    logic        grant_a, grant_b;
    logic        a_in_range, b_in_range;

    assign fsm_state = state;

    // Eligibility, round-robin choice and grid bounds for each requester.
    assign a_elig     = a_req && !a_ack;
    assign b_elig     = b_req && !b_ack;
    assign grant_b    = b_elig && (!a_elig || !last_b);
    assign grant_a    = a_elig && !grant_b;
    assign a_in_range = (a_row < ROW_LIM) && (a_col < COL_LIM);
    assign b_in_range = (b_row < ROW_LIM) && (b_col < COL_LIM);

    // Next-state, fill sweep and next registered outputs.
    always_comb begin
        state_nx     = state;
        row_nx       = row;
        col_nx       = col;
        fill_word_nx = fill_word;
        last_b_nx    = last_b;
        wren_nx      = 1'b0;
        wradr_nx     = wradr;
        wrdata_nx    = wrdata;
        a_ack_nx     = 1'b0;
        b_ack_nx     = 1'b0;
        busy_nx      = 1'b0;
        done_nx      = 1'b0;

        unique case (state)
            ST_FILL: begin
                // row/col hold the cell written last; the sweep ends after (ROWS-1, COLS-1)
                if (row == ROW_LAST && col == COL_LAST) begin
                    state_nx = ST_DONE;
                    done_nx  = 1'b1;
                end else begin
                    busy_nx = 1'b1;
                    wren_nx = 1'b1;
                    if (col == COL_LAST) begin
                        col_nx = '0;
                        row_nx = row + 5'd1;
                    end else begin
                        col_nx = col + 6'd1;
                    end
                    wradr_nx  = {2'b00, row_nx, col_nx};
                    wrdata_nx = fill_word;
                end
            end

            default: begin
                // IDLE and DONE both arbitrate; DONE only differs by its done pulse
                state_nx = ST_IDLE;
                if (fill_start) begin
                    // fill wins over a same-cycle request, which stays pending
                    state_nx     = ST_FILL;
                    fill_word_nx = fill_data;
                    row_nx       = '0;
                    col_nx       = '0;
                    busy_nx      = 1'b1;
                    wren_nx      = 1'b1;
                    wradr_nx     = '0;
                    wrdata_nx    = fill_data;
                end else if (grant_a) begin
                    a_ack_nx  = 1'b1;
                    last_b_nx = 1'b0;
                    wren_nx   = a_in_range;
                    wradr_nx  = {2'b00, a_row, a_col};
                    wrdata_nx = a_data;
                end else if (grant_b) begin
                    b_ack_nx  = 1'b1;
                    last_b_nx = 1'b1;
                    wren_nx   = b_in_range;
                    wradr_nx  = {2'b00, b_row, b_col};
                    wrdata_nx = b_data;
                end
            end
        endcase
    end

    // State, fill counters, fill word and round-robin pointer.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            row       <= '0;
            col       <= '0;
            fill_word <= '0;
            last_b    <= 1'b1;
        end else begin
            state     <= state_nx;
            row       <= row_nx;
            col       <= col_nx;
            fill_word <= fill_word_nx;
            last_b    <= last_b_nx;
        end
    end

    // Registered RAM port, acks and fill status.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            wren      <= 1'b0;
            wradr     <= '0;
            wrdata    <= '0;
            a_ack     <= 1'b0;
            b_ack     <= 1'b0;
            fill_busy <= 1'b0;
            fill_done <= 1'b0;
        end else begin
            wren      <= wren_nx;
            wradr     <= wradr_nx;
            wrdata    <= wrdata_nx;
            a_ack     <= a_ack_nx;
            b_ack     <= b_ack_nx;
            fill_busy <= busy_nx;
            fill_done <= done_nx;
        end
    end

endmodule

// File: tb/tb_txt_wr_arbiter.sv
// Bench for txt_wr_arbiter: directed scenarios plus a random phase, all
// checked against a cycle-level reference model of the arbiter's rules and a
// write scoreboard.
module tb_txt_wr_arbiter;

    localparam int COLS  = 40;
    localparam int ROWS  = 30;
    localparam int CELLS = COLS * ROWS;
    localparam int W     = 29;  // {wradr, wrdata}

    logic        clk = 1'b0;
    logic        reset;
    logic        a_req, b_req;
    logic [4:0]  a_row, b_row;
    logic [5:0]  a_col, b_col;
    logic [15:0] a_data, b_data;
    logic        a_ack, b_ack;
    logic        fill_start;
    logic [15:0] fill_data;
    logic        fill_busy, fill_done;
    logic [12:0] wradr;
    logic [15:0] wrdata;
    logic        wren;
    logic [1:0]  fsm_state;

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_q[$];

    txt_wr_arbiter #(.COLS(COLS), .ROWS(ROWS)) dut (
        .pixel_clock (clk),
        .reset       (reset),
        .a_req       (a_req),
        .a_row       (a_row),
        .a_col       (a_col),
        .a_data      (a_data),
        .a_ack       (a_ack),
        .b_req       (b_req),
        .b_row       (b_row),
        .b_col       (b_col),
        .b_data      (b_data),
        .b_ack       (b_ack),
        .fill_start  (fill_start),
        .fill_data   (fill_data),
        .fill_busy   (fill_busy),
        .fill_done   (fill_done),
        .wradr       (wradr),
        .wrdata      (wrdata),
        .wren        (wren),
        .fsm_state   (fsm_state)
    );

    // clock and reset
    initial forever #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    int          m_fill_idx = -1;   // index of last filled cell, -1 when no fill
    bit          m_last_b   = 1'b1; // most recent grant went to B
    logic        m_wren = 1'b0, m_a_ack = 1'b0, m_b_ack = 1'b0;
    logic        m_busy = 1'b0, m_done = 1'b0;
    logic [15:0] m_fword = '0;

    task automatic m_emit(input int row, input int col, input logic [15:0] data);
        m_wren = 1'b1;
        exp_q.push_back({2'b00, 5'(row), 6'(col), data});
    endtask

    task automatic m_reset();
        m_fill_idx = -1;
        m_last_b   = 1'b1;
        m_wren     = 1'b0;
        m_a_ack    = 1'b0;
        m_b_ack    = 1'b0;
        m_busy     = 1'b0;
        m_done     = 1'b0;
        exp_q.delete();
    endtask

    task automatic m_step();
        bit a_el, b_el, pick_b;
        a_el = a_req && !m_a_ack;
        b_el = b_req && !m_b_ack;
        m_wren = 1'b0; m_a_ack = 1'b0; m_b_ack = 1'b0; m_busy = 1'b0; m_done = 1'b0;
        if (m_fill_idx >= 0) begin
            if (m_fill_idx == CELLS - 1) begin
                m_fill_idx = -1;
                m_done     = 1'b1;
            end else begin
                m_fill_idx++;
                m_busy = 1'b1;
                m_emit(m_fill_idx / COLS, m_fill_idx % COLS, m_fword);
            end
        end else if (fill_start) begin
            m_fill_idx = 0;
            m_fword    = fill_data;
            m_busy     = 1'b1;
            m_emit(0, 0, fill_data);
        end else if (a_el || b_el) begin
            if (a_el && b_el) pick_b = !m_last_b;
            else              pick_b = b_el;
            m_last_b = pick_b;
            if (pick_b) begin
                m_b_ack = 1'b1;
                if (int'(b_row) < ROWS && int'(b_col) < COLS) m_emit(b_row, b_col, b_data);
            end else begin
                m_a_ack = 1'b1;
                if (int'(a_row) < ROWS && int'(a_col) < COLS) m_emit(a_row, a_col, a_data);
            end
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) m_reset();
        else       m_step();
    end

    // scoreboard and per-cycle control check, sampled away from the active edge
    always @(negedge clk) begin
        logic [W-1:0] e;
        check_eq("ctl", 64'({wren, a_ack, b_ack, fill_busy, fill_done}),
                        64'({m_wren, m_a_ack, m_b_ack, m_busy, m_done}));
        if (wren === 1'b1) begin
            check_eq("sb_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("sb_write", 64'({wradr, wrdata}), 64'(e));
            end
        end
    end

    // ---------------- driver helpers ----------------
    function automatic logic [4:0] rand_row();
        return ($urandom_range(7) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(ROWS - 1));
    endfunction

    function automatic logic [5:0] rand_col();
        return ($urandom_range(7) == 0) ? 6'($urandom_range(63)) : 6'($urandom_range(COLS - 1));
    endfunction

    task automatic idle_inputs();
        a_req = 1'b0; b_req = 1'b0; fill_start = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0]  wpat4, apat4;
        logic [5:0]  apat, bpat, wpat;
        int          writes, done_cyc, ack_cyc, addr_bad, data_bad, dones;
        logic [5:0]  max_col;
        logic [12:0] last_adr;

        reset = 1'b0;
        a_req = 1'b0; a_row = '0; a_col = '0; a_data = '0;
        b_req = 1'b0; b_row = '0; b_col = '0; b_data = '0;
        fill_start = 1'b0; fill_data = '0;

        // reset with both requesting: everything zero
        #1;
        a_req = 1'b1; a_row = 5'd2; a_col = 6'd7; a_data = 16'h1111;
        b_req = 1'b1; b_row = 5'd4; b_col = 6'd9; b_data = 16'h2222;
        reset = 1'b1;
        #1;
        check_eq("reset_outs", 64'({wren, wradr, wrdata, a_ack, b_ack, fill_busy, fill_done}), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // first tie after reset goes to A
        @(negedge clk);
        check_eq("first_grant_ctl", 64'({a_ack, b_ack, wren}), 64'(3'b101));
        check_eq("first_grant_adr", 64'(wradr), 64'(13'h087));
        check_eq("first_grant_dat", 64'(wrdata), 64'(16'h1111));
        idle_inputs();
        repeat (2) @(negedge clk);

        // single requester held for 4 cycles: write every other cycle
        a_req = 1'b1; a_row = 5'd3; a_col = 6'd5; a_data = 16'h7241;
        wpat4 = '0; apat4 = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wpat4 = {wpat4[2:0], wren};
            apat4 = {apat4[2:0], a_ack};
            if (i == 0 || i == 2) begin
                check_eq("single_adr", 64'(wradr), 64'(13'h0C5));
                check_eq("single_dat", 64'(wrdata), 64'(16'h7241));
            end
        end
        idle_inputs();
        check_eq("single_wren_pat", 64'(wpat4), 64'(4'b1010));
        check_eq("single_ack_pat", 64'(apat4), 64'(4'b1010));
        repeat (2) @(negedge clk);

        // contention: last grant was A, so B first, then strict alternation
        a_req = 1'b1; a_row = 5'd10; a_col = 6'd20; a_data = 16'hAAAA;
        b_req = 1'b1; b_row = 5'd11; b_col = 6'd21; b_data = 16'hBBBB;
        apat = '0; bpat = '0; wpat = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            apat = {apat[4:0], a_ack};
            bpat = {bpat[4:0], b_ack};
            wpat = {wpat[4:0], wren};
        end
        idle_inputs();
        check_eq("cont_a_pat", 64'(apat), 64'(6'b010101));
        check_eq("cont_b_pat", 64'(bpat), 64'(6'b101010));
        check_eq("cont_wren_pat", 64'(wpat), 64'(6'b111111));
        repeat (2) @(negedge clk);

        // out-of-range row: acked, not written
        b_req = 1'b1; b_row = 5'd30; b_col = 6'd0; b_data = 16'h3333;
        @(negedge clk);
        check_eq("oor_ctl", 64'({b_ack, wren}), 64'(2'b10));
        idle_inputs();
        repeat (2) @(negedge clk);

        // full fill, A requesting in the same cycle and held throughout,
        // with a second fill_start mid-fill that must be ignored
        fill_start = 1'b1; fill_data = 16'h0720;
        a_req = 1'b1; a_row = 5'd5; a_col = 6'd6; a_data = 16'h4444;
        writes = 0; done_cyc = 0; ack_cyc = 0; addr_bad = 0; data_bad = 0;
        max_col = '0; last_adr = '0;
        for (int i = 1; i <= 1300 && ack_cyc == 0; i++) begin
            @(negedge clk);
            fill_start = (i == 600);
            fill_data  = (i == 600) ? 16'h1234 : 16'h0720;
            if (wren && fill_busy) begin
                if (wradr[5:0] > max_col) max_col = wradr[5:0];
                if (int'(wradr) != (((writes / COLS) << 6) | (writes % COLS))) addr_bad++;
                if (wrdata != 16'h0720) data_bad++;
                last_adr = wradr;
                writes++;
            end
            if (fill_done && done_cyc == 0) done_cyc = i;
            if (a_ack) ack_cyc = i;
        end
        idle_inputs();
        check_eq("fill_writes", 64'(writes), 64'(CELLS));
        check_eq("fill_addr_seq", 64'(addr_bad), 64'd0);
        check_eq("fill_data", 64'(data_bad), 64'd0);
        check_eq("fill_max_col", 64'(max_col), 64'(COLS - 1));
        check_eq("fill_last_adr", 64'(last_adr), 64'(13'h767));  // cell (29,39)
        check_eq("fill_done_cyc", 64'(done_cyc), 64'(CELLS + 1));
        check_eq("fill_defer_ack", 64'(ack_cyc), 64'(CELLS + 2));
        repeat (2) @(negedge clk);

        // reset at write 600: port quiet at once, no done pulse afterwards
        fill_start = 1'b1; fill_data = 16'h5A5A;
        writes = 0;
        for (int i = 1; i <= 700 && writes < 600; i++) begin
            @(negedge clk);
            fill_start = 1'b0;
            if (wren) writes++;
        end
        check_eq("mid_reach_600", 64'(writes), 64'd600);
        #2 reset = 1'b1;
        #1;
        check_eq("mid_reset_outs", 64'({wren, wradr, wrdata, a_ack, b_ack, fill_busy, fill_done}), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        writes = 0; dones = 0;
        for (int i = 0; i < 1300; i++) begin
            @(negedge clk);
            if (wren) writes++;
            if (fill_done) dones++;
        end
        check_eq("mid_no_writes", 64'(writes), 64'd0);
        check_eq("mid_no_done", 64'(dones), 64'd0);

        // random traffic against the model
        for (int cyc = 0; cyc < 5000; cyc++) begin
            @(negedge clk);
            if (!a_req || a_ack) begin
                a_req = ($urandom_range(3) != 0);
                a_row = rand_row(); a_col = rand_col(); a_data = 16'($urandom);
            end else if ($urandom_range(15) == 0) begin
                a_req = 1'b0;
            end
            if (!b_req || b_ack) begin
                b_req = ($urandom_range(3) != 0);
                b_row = rand_row(); b_col = rand_col(); b_data = 16'($urandom);
            end else if ($urandom_range(15) == 0) begin
                b_req = 1'b0;
            end
            fill_start = ($urandom_range(799) == 0);
            fill_data  = 16'($urandom);
        end
        idle_inputs();
        repeat (1300) @(negedge clk);
        check_eq("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
